round_timer: RTL and testbench
==============================

ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 Parameter DEFAULT_BCD, 8'h30, two-digit BCD seconds value loaded at reset.
REQ-002 Parameter WARN_SECS, 5, binary threshold in seconds; warn asserts while the remaining time is at or below this value.
REQ-003 Reset rst, synchronous, active-low; clock clk.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 tick_1s  input  1  one-cycle 1-second strobe from the seconds counter.
REQ-007 load  input  1  one-cycle strobe: capture load_val as the new time.
REQ-008 load_val  input  8  BCD seconds, [7:4] tens, [3:0] ones.
REQ-009 start  input  1  one-cycle strobe: begin or resume the countdown.
REQ-010 pause  input  1  one-cycle strobe: freeze the countdown.
REQ-011 time_tens  output  4  registered BCD tens digit of the remaining time.
REQ-012 time_ones  output  4  registered BCD ones digit of the remaining time.
REQ-013 running  output  1  high while in RUN.
REQ-014 warn  output  1  high in RUN or PAUSE while the remaining value is nonzero and <= WARN_SECS.
REQ-015 time_up  output  1  one-cycle pulse on expiry.
REQ-016 expired  output  1  level, high while in EXPIRED.

Function
REQ-017 FSM states: IDLE, RUN, PAUSE, EXPIRED; state and all outputs are registered.
REQ-018 Per-cycle input priority: load > pause > start > tick_1s; a lower-priority input asserted in the same cycle as a higher one is ignored.
REQ-019 load, in any state, captures load_val and forces IDLE in the next cycle; time_up is not generated.
REQ-020 load digit rule: any nibble > 9 is clamped to 9, so 8'hA7 loads as 97.
REQ-021 start in IDLE or PAUSE with a nonzero value enters RUN in the next cycle.
REQ-022 start with value 00, or start in RUN or EXPIRED, has no effect.
REQ-023 pause in RUN enters PAUSE; pause in any other state has no effect.
REQ-024 tick_1s in RUN decrements the value by one as a BCD decrement with ones-to-tens borrow (40 -> 39, 10 -> 09); the new value is visible one cycle after the tick.
REQ-025 tick_1s in IDLE, PAUSE or EXPIRED is ignored; ticks are never queued.
REQ-026 Expiry: on a RUN tick with value 01, the value becomes 00 and the state becomes EXPIRED in the same next cycle.
REQ-027 On the expiry transition, time_up is high for exactly that one cycle; expired stays high until load or reset.
REQ-028 No wrap-around: the value never decrements below 00.
REQ-029 warn is combinationally derived only from registered state and value; a registered version is acceptable if it lags by at most one cycle.

Reset
REQ-030 While rst = 0 at a clock edge, the block SHALL enter IDLE with value = DEFAULT_BCD, running = 0, warn = 0, time_up = 0 and expired = 0.
REQ-031 Reset asserted mid-RUN aborts the countdown with no time_up pulse; the first clock after release accepts inputs normally.

Structure
REQ-032 The shared package round_timer_pkg SHALL hold the state enum and the BCD width constant (4).
REQ-033 The BCD decrement and clamp logic SHALL be a combinational sub-module bcd_dec2 (8-bit BCD in; 8-bit BCD out plus zero flag), reusable by score/display blocks.
REQ-034 The FSM and the registers SHALL reside in round_timer only; there SHALL be no clock division inside this block.

Verification
REQ-035 Reset, then start, then 30 ticks spaced 10 cycles apart -> digits step 30, 29 ... 01, 00; time_up pulses once; expired = 1; running = 0.
REQ-036 load 8'h10, start, one tick -> value 09 (borrow correct); warn rises when the value reaches 05.
REQ-037 In RUN, pause and tick_1s in the same cycle -> PAUSE, value unchanged; later ticks ignored; start resumes and the next tick decrements.
REQ-038 In EXPIRED, load 8'hA7 -> IDLE, value 97, expired = 0; start with value 00 after load 8'h00 -> stays IDLE.
REQ-039 Assert rst for one cycle at value 02 in RUN -> IDLE, value 30, no time_up ever asserted.
REQ-040 Simultaneous load and start -> IDLE with the loaded value; the next start enters RUN.

Source files
------------

// File: rtl/round_timer_pkg.sv
// Shared types and constants for the round timer and its BCD helpers.
package round_timer_pkg;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    // Countdown controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Saturate a nibble to the largest legal BCD digit.
    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Binary value (0..99) of a legal two-digit BCD number.
    function automatic logic [6:0] bcd_to_bin(input logic [2*BCD_W-1:0] v);
        return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
    endfunction

endpackage

// File: rtl/bcd_dec2.sv
// Two-digit BCD clamp and saturating decrement (combinational).
// Each nibble above 9 is clamped to 9; with dec_en_i set, the clamped value
// is then decremented with ones-to-tens borrow, stopping at 00.
module bcd_dec2
    import round_timer_pkg::*;
(
    input  logic [2*BCD_W-1:0] bcd_i,
    input  logic               dec_en_i,
    output logic [2*BCD_W-1:0] bcd_o,
    output logic               zero_o
);

    logic [2*BCD_W-1:0] clamped;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_clamp
            assign clamped[gi*BCD_W +: BCD_W] = clamp_digit(bcd_i[gi*BCD_W +: BCD_W]);
        end
    endgenerate

    // Pass the clamped value through, or decrement it with borrow and no wrap.
    always_comb begin
        bcd_o = clamped;
        if (dec_en_i) begin
            if (clamped == 8'h00) begin
                bcd_o = 8'h00;
            end else if (clamped[3:0] == 4'd0) begin
                bcd_o = {clamped[7:4] - 4'd1, 4'd9};
            end else begin
                bcd_o = {clamped[7:4], clamped[3:0] - 4'd1};
            end
        end
    end

    assign zero_o = (bcd_o == 8'h00);

endmodule

// File: rtl/round_timer.sv
// Round countdown timer: BCD seconds value counted down by an external
// 1-second strobe, with load / start / pause control and expiry signalling.
module round_timer
    import round_timer_pkg::*;
#(
    parameter logic [7:0] DEFAULT_BCD = 8'h30,
    parameter int         WARN_SECS   = 5
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] time_tens,
    output logic [3:0] time_ones,
    output logic       running,
    output logic       warn,
    output logic       time_up,
    output logic       expired
);

    localparam logic [6:0] WARN_BIN = 7'(WARN_SECS);

    state_t     state_q;
    logic [7:0] value_q;
    logic       running_q;
    logic       time_up_q;
    logic       expired_q;

    logic [7:0] value_d;
    logic       value_zero_d;

    // One shared helper: clamps load_val on a load, otherwise decrements
    // the current value (only used on a RUN tick).
    bcd_dec2 u_bcd_dec2 (
        .bcd_i    (load ? load_val : value_q),
        .dec_en_i (~load),
        .bcd_o    (value_d),
        .zero_o   (value_zero_d)
    );

    // Controller: prioritised load > pause > start > tick, registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            value_q   <= DEFAULT_BCD;
            running_q <= 1'b0;
            time_up_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            time_up_q <= 1'b0;
            if (load) begin
                value_q   <= value_d;
                state_q   <= IDLE;
                running_q <= 1'b0;
                expired_q <= 1'b0;
            end else if (pause) begin
                if (state_q == RUN) begin
                    state_q   <= PAUSE;
                    running_q <= 1'b0;
                end
            end else if (start) begin
                if ((state_q == IDLE || state_q == PAUSE) && value_q != 8'h00) begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                end
            end else if (tick_1s && state_q == RUN) begin
                value_q <= value_d;
                if (value_zero_d) begin
                    state_q   <= EXPIRED;
                    running_q <= 1'b0;
                    expired_q <= 1'b1;
                    time_up_q <= 1'b1;
                end
            end
        end
    end

    assign time_tens = value_q[7:4];
    assign time_ones = value_q[3:0];
    assign running   = running_q;
    assign time_up   = time_up_q;
    assign expired   = expired_q;

    // Low-time warning, decoded straight from the registered state and value.
    assign warn = (state_q == RUN || state_q == PAUSE) &&
                  (value_q != 8'h00) &&
                  (bcd_to_bin(value_q) <= WARN_BIN);

endmodule

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer: a directed vector table, two
// multi-cycle sequences and a randomized run against a seconds-level model.
module tb_round_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1s;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [3:0] time_tens;
    logic [3:0] time_ones;
    logic       running;
    logic       warn;
    logic       time_up;
    logic       expired;

    round_timer dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1s   (tick_1s),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .pause     (pause),
        .time_tens (time_tens),
        .time_ones (time_ones),
        .running   (running),
        .warn      (warn),
        .time_up   (time_up),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int up_count = 0;

    // Reference model: remaining time as a plain integer number of seconds.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXP} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_secs = 30;
    bit    m_up   = 1'b0;

    typedef struct {
        bit         ld;
        logic [7:0] lv;
        bit         st;
        bit         pa;
        bit         tk;
        logic [7:0] e_val;
        bit         e_run;
        bit         e_warn;
        bit         e_up;
        bit         e_exp;
    } vec_t;

    vec_t vecs[$];

    function automatic int load_secs(logic [7:0] v);
        int t;
        int o;
        t = int'(v[7:4]);
        o = int'(v[3:0]);
        if (t > 9) t = 9;
        if (o > 9) o = 9;
        return t * 10 + o;
    endfunction

    task automatic model_update(bit r, bit ld, logic [7:0] lv, bit st, bit pa, bit tk);
        m_up = 1'b0;
        if (!r) begin
            m_mode = M_IDLE;
            m_secs = 30;
        end else if (ld) begin
            m_secs = load_secs(lv);
            m_mode = M_IDLE;
        end else if (pa) begin
            if (m_mode == M_RUN) m_mode = M_PAUSE;
        end else if (st) begin
            if ((m_mode == M_IDLE || m_mode == M_PAUSE) && m_secs > 0) m_mode = M_RUN;
        end else if (tk && m_mode == M_RUN) begin
            if (m_secs > 0) m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_mode = M_EXP;
                m_up   = 1'b1;
            end
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_model(string tag);
        bit w;
        w = (m_mode == M_RUN || m_mode == M_PAUSE) && m_secs > 0 && m_secs <= 5;
        chk({tag, ".tens"},    int'(time_tens), m_secs / 10);
        chk({tag, ".ones"},    int'(time_ones), m_secs % 10);
        chk({tag, ".running"}, int'(running),   int'(m_mode == M_RUN));
        chk({tag, ".expired"}, int'(expired),   int'(m_mode == M_EXP));
        chk({tag, ".time_up"}, int'(time_up),   int'(m_up));
        chk({tag, ".warn"},    int'(warn),      int'(w));
    endtask

    // Apply one cycle of inputs, sample 1 time unit after the edge.
    task automatic step(bit r, bit ld, logic [7:0] lv, bit st, bit pa, bit tk);
        rst      = r;
        load     = ld;
        load_val = lv;
        start    = st;
        pause    = pa;
        tick_1s  = tk;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        load    = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        tick_1s = 1'b0;
        cyc++;
        model_update(r, ld, lv, st, pa, tk);
        if (time_up) up_count++;
        $display("[TB] cyc=%0d rst=%0b ld=%0b lv=%02h st=%0b pa=%0b tk=%0b -> %0h%0h run=%0b warn=%0b up=%0b exp=%0b",
                 cyc, r, ld, lv, st, pa, tk, time_tens, time_ones, running, warn, time_up, expired);
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check_model("gap");
        end
    endtask

    initial begin
        // Vectors from IDLE at 30, hand-derived expectations.
        //            ld  lv     st  pa  tk  val    run warn up exp
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'hA7, 1'b0, 1'b0, 1'b0, 8'h97, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h98, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h39, 1'b0, 1'b0, 1'b0, 1'b0});

        rst = 1'b0; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0; tick_1s = 1'b0;

        // Reset state.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("reset.value",   int'({time_tens, time_ones}), 'h30);
        chk("reset.running", int'(running), 0);
        chk("reset.warn",    int'(warn),    0);
        chk("reset.time_up", int'(time_up), 0);
        chk("reset.expired", int'(expired), 0);

        // Directed vector table.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa, vecs[i].tk);
            chk($sformatf("vec%0d.value", i),   int'({time_tens, time_ones}), int'(vecs[i].e_val));
            chk($sformatf("vec%0d.running", i), int'(running), int'(vecs[i].e_run));
            chk($sformatf("vec%0d.warn", i),    int'(warn),    int'(vecs[i].e_warn));
            chk($sformatf("vec%0d.time_up", i), int'(time_up), int'(vecs[i].e_up));
            chk($sformatf("vec%0d.expired", i), int'(expired), int'(vecs[i].e_exp));
        end

        // Full countdown from the default, ticks spaced 10 cycles apart.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_model("full.reset");
        up_count = 0;
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_model("full.start");
        for (int k = 1; k <= 30; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            check_model("full.tick");
            chk("full.digits", int'({time_tens, time_ones}), (((30 - k) / 10) << 4) | ((30 - k) % 10));
            idle_cycles(9);
        end
        chk("full.time_up_count", up_count, 1);
        chk("full.expired", int'(expired), 1);
        chk("full.running", int'(running), 0);

        // Reset mid-RUN at 02 aborts without a time_up pulse.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        up_count = 0;
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 28; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            check_model("abort.tick");
            idle_cycles(1);
        end
        chk("abort.before", int'({time_tens, time_ones}), 'h02);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("abort.value",   int'({time_tens, time_ones}), 'h30);
        chk("abort.running", int'(running), 0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("abort.restart", int'(running), 1);
        idle_cycles(3);
        chk("abort.time_up_count", up_count, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bit         r;
            bit         ld;
            logic [7:0] lv;
            r  = ($urandom_range(99) != 0);
            ld = ($urandom_range(99) < 4);
            if ($urandom_range(1) == 1) lv = 8'($urandom_range(255));
            else                        lv = 8'({4'($urandom_range(1)), 4'($urandom_range(9))});
            step(r, ld, lv, $urandom_range(99) < 15, $urandom_range(99) < 6, $urandom_range(99) < 40);
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
